// File: rtl/map_pkg.sv
// Shared tile codes, request opcodes and controller states for the tile-map
// write-port sequencer.
package map_pkg;

  localparam int MAP_W    = 40;
  localparam int MAP_H    = 30;
  localparam int MAP_SIZE = MAP_W * MAP_H;

  localparam logic [3:0] TILE_EMPTY  = 4'd0;
  localparam logic [3:0] TILE_WALL   = 4'd1;
  localparam logic [3:0] TILE_PELLET = 4'd2;
  localparam logic [3:0] TILE_POWER  = 4'd3;

  typedef enum logic [1:0] {
    OP_WRITE    = 2'b00,
    OP_CONSUME  = 2'b01,
    OP_READ     = 2'b10,
    OP_READ_ALT = 2'b11
  } map_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_EVAL,
    S_WR
  } ctrl_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last
// accepted grantee; the pointer only moves when the grant is accepted.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cidx;
  logic             found;
  int               cand;

  // Scan from ptr+1 around to ptr itself so the last grantee is lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cidx      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      cidx = IDX_W'(cand);
      if (!found && req[cidx]) begin
        found       = 1'b1;
        grant[cidx] = 1'b1;
        grant_idx   = cidx;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ptr <= IDX_W'(NUM_REQ - 1);
    end else if (accept) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/map_update_ctrl.sv
// Serialises tile read-modify-write requests onto the map RAM's write port
// and keeps the remaining pellet count.
module map_update_ctrl #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 4,
  parameter int MAP_SIZE     = 1200,
  parameter int INIT_PELLETS = 244
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [2*NUM_REQ-1:0]      req_op,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         resp_tile,
  output logic                      resp_hit,
  output logic                      resp_err,
  output logic [ADDR_W-1:0]         ram_read_address,
  input  logic [DATA_W-1:0]         ram_data_Out,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_write_address,
  output logic [DATA_W-1:0]         ram_data_In,
  input  logic                      level_reload,
  output logic [10:0]               pellets_left,
  output logic                      pellet_eaten,
  output logic                      power_eaten,
  output logic                      level_clear
);
  import map_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W:0] ADDR_LIMIT   = (ADDR_W + 1)'(MAP_SIZE);
  localparam logic [10:0]     CNT_MAX      = 11'(MAP_SIZE);
  localparam logic [10:0]     CNT_INIT     = 11'(INIT_PELLETS);
  localparam logic [DATA_W-1:0] T_EMPTY  = DATA_W'(TILE_EMPTY);
  localparam logic [DATA_W-1:0] T_PELLET = DATA_W'(TILE_PELLET);
  localparam logic [DATA_W-1:0] T_POWER  = DATA_W'(TILE_POWER);

  ctrl_state_t        state, next_state;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               accept;

  logic [IDX_W-1:0]   idx_q;
  map_op_t            op_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic               err_q;
  logic [DATA_W-1:0]  old_q;

  logic [DATA_W-1:0]  new_tile;
  logic               old_pel, new_pel;
  logic               cnt_dec, cnt_inc;

  logic [1:0]         op_v   [NUM_REQ];
  logic [ADDR_W-1:0]  addr_v [NUM_REQ];
  logic [DATA_W-1:0]  data_v [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_v[g]   = req_op[2*g +: 2];
    assign addr_v[g] = req_addr[ADDR_W*g +: ADDR_W];
    assign data_v[g] = req_data[DATA_W*g +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .Clk       (Clk),
    .Reset     (Reset),
    .req       (req),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept            = (state == S_IDLE) && (|grant);
  assign ram_read_address  = addr_q;
  assign ram_write_address = addr_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Transaction context is captured at grant so requesters may change inputs afterwards.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx_q  <= '0;
      op_q   <= OP_WRITE;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      old_q  <= '0;
    end else begin
      if (accept) begin
        idx_q  <= grant_idx;
        op_q   <= map_op_t'(op_v[grant_idx]);
        addr_q <= addr_v[grant_idx];
        data_q <= data_v[grant_idx];
        err_q  <= ({1'b0, addr_v[grant_idx]} >= ADDR_LIMIT);
      end
      if (state == S_EVAL) begin
        old_q <= ram_data_Out;
      end
    end
  end

  always_comb begin
    next_state   = state;
    ack          = '0;
    resp_tile    = '0;
    resp_hit     = 1'b0;
    resp_err     = 1'b0;
    ram_we       = 1'b0;
    ram_data_In  = '0;
    pellet_eaten = 1'b0;
    power_eaten  = 1'b0;
    new_tile     = old_q;
    old_pel      = (old_q == T_PELLET) || (old_q == T_POWER);
    new_pel      = 1'b0;
    cnt_dec      = 1'b0;
    cnt_inc      = 1'b0;
    case (state)
      S_IDLE: if (|grant) next_state = S_RD;
      S_RD:   next_state = S_EVAL;
      S_EVAL: next_state = S_WR;
      S_WR: begin
        next_state = S_IDLE;
        ack[idx_q] = 1'b1;
        resp_err   = err_q;
        // Out-of-range requests complete normally but never touch RAM or the count.
        if (!err_q) begin
          resp_tile = old_q;
          case (op_q)
            OP_WRITE: begin
              ram_we   = 1'b1;
              new_tile = data_q;
            end
            OP_CONSUME: begin
              if (old_pel) begin
                ram_we       = 1'b1;
                new_tile     = T_EMPTY;
                resp_hit     = 1'b1;
                pellet_eaten = (old_q == T_PELLET);
                power_eaten  = (old_q == T_POWER);
              end
            end
            default: ;
          endcase
          new_pel     = (new_tile == T_PELLET) || (new_tile == T_POWER);
          cnt_dec     = old_pel && !new_pel;
          cnt_inc     = !old_pel && new_pel;
          ram_data_In = ram_we ? new_tile : '0;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // A reload in the same cycle as an update discards that update.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pellets_left <= CNT_INIT;
      level_clear  <= 1'b0;
    end else begin
      level_clear <= (pellets_left == 11'd0);
      if (level_reload) begin
        pellets_left <= CNT_INIT;
      end else if (cnt_dec && (pellets_left != 11'd0)) begin
        pellets_left <= pellets_left - 11'd1;
      end else if (cnt_inc && (pellets_left < CNT_MAX)) begin
        pellets_left <= pellets_left + 11'd1;
      end
    end
  end

endmodule

// File: tb/tb_map_update_ctrl.sv
// Scoreboard bench for map_update_ctrl: a tile-map reference model predicts each
// completion, and a monitor compares whenever an ack pulse appears.
module tb_map_update_ctrl;

  localparam int NREQ  = 4;
  localparam int MSIZE = 1200;
  localparam int INIT  = 244;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [7:0]  req_op = '0;
  logic [47:0] req_addr = '0;
  logic [15:0] req_data = '0;
  logic [3:0]  ack;
  logic [3:0]  resp_tile;
  logic        resp_hit, resp_err;
  logic [11:0] ram_read_address;
  logic [3:0]  ram_data_Out = '0;
  logic        ram_we;
  logic [11:0] ram_write_address;
  logic [3:0]  ram_data_In;
  logic        level_reload = 1'b0;
  logic [10:0] pellets_left;
  logic        pellet_eaten, power_eaten, level_clear;

  map_update_ctrl dut (
    .Clk               (clk),
    .Reset             (rst),
    .req               (req),
    .req_op            (req_op),
    .req_addr          (req_addr),
    .req_data          (req_data),
    .ack               (ack),
    .resp_tile         (resp_tile),
    .resp_hit          (resp_hit),
    .resp_err          (resp_err),
    .ram_read_address  (ram_read_address),
    .ram_data_Out      (ram_data_Out),
    .ram_we            (ram_we),
    .ram_write_address (ram_write_address),
    .ram_data_In       (ram_data_In),
    .level_reload      (level_reload),
    .pellets_left      (pellets_left),
    .pellet_eaten      (pellet_eaten),
    .power_eaten       (power_eaten),
    .level_clear       (level_clear)
  );

  always #5 clk = ~clk;

  // Environment RAM with one-cycle registered read.
  logic [3:0] ram [0:4095];
  always @(posedge clk) begin
    ram_data_Out <= ram[ram_read_address];
    if (ram_we) ram[ram_write_address] <= ram_data_In;
  end

  typedef struct {
    int who; int tile; int hit; int err; int we; int waddr; int wdata;
    int pe; int pw; int cnt; int gap;
  } exp_t;

  exp_t exp_q[$];
  int   mdl_map [0:MSIZE-1];
  int   mdl_count;
  int   mdl_ptr;
  int   total = 0;
  int   bad = 0;
  int   st_op [4];
  int   st_addr [4];
  int   st_data [4];
  bit   mon_en = 1'b0;
  int   cyc = 0;

  task automatic checkOutput(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d want=%0d", name, act, want);
    end
  endtask

  function automatic bit is_pel(input int t);
    return (t == 2) || (t == 3);
  endfunction

  // Reference semantics of one serialised transaction against the model map.
  function automatic exp_t model_txn(input int who, input int op, input int addr, input int data);
    exp_t e;
    int   oldv, newv;
    e = '{default: 0};
    e.who = who;
    if (addr >= MSIZE) begin
      e.err = 1;
    end else begin
      oldv = mdl_map[addr];
      newv = oldv;
      e.tile = oldv;
      if (op == 0) begin
        e.we = 1; newv = data;
      end else if (op == 1 && is_pel(oldv)) begin
        e.we = 1; newv = 0; e.hit = 1;
        e.pe = (oldv == 2); e.pw = (oldv == 3);
      end
      e.waddr = addr; e.wdata = newv;
      if (is_pel(oldv) && !is_pel(newv)) mdl_count = (mdl_count > 0) ? mdl_count - 1 : 0;
      if (!is_pel(oldv) && is_pel(newv)) mdl_count = (mdl_count < MSIZE) ? mdl_count + 1 : MSIZE;
      mdl_map[addr] = newv;
    end
    e.cnt = mdl_count;
    return e;
  endfunction

  // All masked requesters raise together while idle and hold until their own ack.
  task automatic applyStimulus(input logic [3:0] mask);
    bit first = 1'b1;
    int n;
    @(negedge clk);
    for (int k = 1; k <= NREQ; k++) begin
      int w;
      w = (mdl_ptr + k) % NREQ;
      if (mask[w]) begin
        exp_t e;
        e = model_txn(w, st_op[w], st_addr[w], st_data[w]);
        e.gap = first ? 0 : 1;
        first = 1'b0;
        exp_q.push_back(e);
        n = w;
      end
    end
    if (mask != 0) mdl_ptr = n;
    for (int w = 0; w < NREQ; w++) begin
      req_op[2*w +: 2]    = 2'(st_op[w]);
      req_addr[12*w +: 12] = 12'(st_addr[w]);
      req_data[4*w +: 4]   = 4'(st_data[w]);
    end
    req = mask;
    for (int c = 0; c < 40 && req != 0; c++) begin
      @(negedge clk);
      req = req & ~ack;
    end
    if (req != 0) begin
      checkOutput("ack_timeout", int'(req), 0);
      req = '0;
      exp_q.delete();
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops one expectation per ack; count and clear flag follow on later cycles.
  exp_t mon_e;
  bit   cnt_pend = 0, clr_pend = 0;
  int   cnt_exp = 0, clr_exp = 0, last_ack = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (clr_pend) begin
        checkOutput("level_clear", int'(level_clear), int'(clr_exp == 0));
        clr_pend = 0;
      end
      if (cnt_pend) begin
        checkOutput("pellets_left", int'(pellets_left), cnt_exp);
        cnt_pend = 0; clr_pend = 1; clr_exp = cnt_exp;
      end
      if (ack != 0) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_ack", int'(ack), 0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("ack_onehot", int'(ack), 1 << mon_e.who);
          checkOutput("resp_tile", int'(resp_tile), mon_e.tile);
          checkOutput("resp_hit", int'(resp_hit), mon_e.hit);
          checkOutput("resp_err", int'(resp_err), mon_e.err);
          checkOutput("ram_we", int'(ram_we), mon_e.we);
          if (mon_e.we != 0) begin
            checkOutput("wr_addr", int'(ram_write_address), mon_e.waddr);
            checkOutput("wr_data", int'(ram_data_In), mon_e.wdata);
          end
          checkOutput("pellet_eaten", int'(pellet_eaten), mon_e.pe);
          checkOutput("power_eaten", int'(power_eaten), mon_e.pw);
          if (mon_e.gap != 0) checkOutput("ack_spacing", cyc - last_ack, 4);
          last_ack = cyc;
          cnt_pend = 1; cnt_exp = mon_e.cnt;
        end
      end else if (ram_we) begin
        checkOutput("stray_we", 1, 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    logic [3:0] m;
    for (int i = 0; i < 4096; i++) ram[i] = 4'($urandom_range(0, 3));
    for (int i = 0; i < MSIZE; i++) mdl_map[i] = int'(ram[i]);
    mdl_count = INIT;
    mdl_ptr   = NREQ - 1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_pellets", int'(pellets_left), INIT);
    checkOutput("rst_clear", int'(level_clear), 0);
    checkOutput("rst_ack", int'(ack), 0);
    checkOutput("rst_we", int'(ram_we), 0);
    mon_en = 1'b1;

    $display("[TB] consume pellet at 85");
    ram[85] = 4'd2; mdl_map[85] = 2;
    st_op[0] = 1; st_addr[0] = 85; st_data[0] = 0;
    applyStimulus(4'b0001);
    settle();
    checkOutput("t1_count", int'(pellets_left), 243);

    $display("[TB] consume wall at 85");
    ram[85] = 4'd1; mdl_map[85] = 1;
    applyStimulus(4'b0001);
    settle();
    checkOutput("t2_count", int'(pellets_left), 243);

    $display("[TB] out-of-range write");
    st_op[1] = 0; st_addr[1] = 1200; st_data[1] = 2;
    applyStimulus(4'b0010);
    settle();

    $display("[TB] four requesters held");
    for (int w = 0; w < NREQ; w++) begin
      st_op[w] = 1; st_addr[w] = 100 + w; st_data[w] = 0;
    end
    applyStimulus(4'b1111);
    settle();

    $display("[TB] drain pellets to zero");
    k = mdl_count - 1;
    for (int j = 0; j < k; j++) begin ram[j] = 4'd2; mdl_map[j] = 2; end
    ram[1199] = 4'd3; mdl_map[1199] = 3;
    for (int j = 0; j < k; j += 4) begin
      m = '0;
      for (int w = 0; w < NREQ; w++) begin
        st_op[w] = 1; st_addr[w] = j + w; st_data[w] = 0;
        if (j + w < k) m[w] = 1'b1;
      end
      applyStimulus(m);
    end
    settle();
    checkOutput("t5_one_left", int'(pellets_left), 1);
    st_op[2] = 1; st_addr[2] = 1199; st_data[2] = 0;
    applyStimulus(4'b0100);
    settle();
    checkOutput("t5_zero", int'(pellets_left), 0);
    checkOutput("t5_clear", int'(level_clear), 1);
    level_reload = 1'b1;
    @(negedge clk);
    level_reload = 1'b0;
    mdl_count = INIT;
    checkOutput("t5_reload", int'(pellets_left), INIT);
    @(negedge clk);
    checkOutput("t5_clear_drop", int'(level_clear), 0);

    $display("[TB] reset during write");
    mon_en = 1'b0; cnt_pend = 0; clr_pend = 0;
    ram[10] = 4'd0; mdl_map[10] = 0;
    req_op[1:0] = 2'b00; req_addr[11:0] = 12'd10; req_data[3:0] = 4'd2;
    req = 4'b0001;
    k = 0;
    for (int c = 0; c < 20 && k == 0; c++) begin
      @(negedge clk);
      if (ack[0]) k = 1;
    end
    checkOutput("t6_ack_seen", k, 1);
    rst = 1'b1;
    #1;
    checkOutput("t6_we", int'(ram_we), 0);
    checkOutput("t6_ack", int'(ack), 0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_count", int'(pellets_left), INIT);
    checkOutput("t6_ram", int'(ram[10]), 0);
    mdl_count = INIT; mdl_ptr = NREQ - 1;
    mon_en = 1'b1;

    $display("[TB] random batches");
    for (int b = 0; b < 150; b++) begin
      for (int w = 0; w < NREQ; w++) begin
        st_op[w] = int'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
          0:       st_addr[w] = int'($urandom_range(1200, 4095));
          1, 2, 3: st_addr[w] = int'($urandom_range(0, 7));
          default: st_addr[w] = int'($urandom_range(0, 1199));
        endcase
        st_data[w] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3))
                                                 : int'($urandom_range(0, 15));
      end
      m = 4'($urandom_range(1, 15));
      applyStimulus(m);
    end
    settle();
    checkOutput("final_count", int'(pellets_left), mdl_count);
    checkOutput("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
